// File: rtl/dnoc_sync_collector.sv
// Barrier sync collector: waits for acks from every node in a target mask.
// Optional watchdog enabled with `define DNOC_SYNC_TIMEOUT_EN.
module dnoc_sync_collector #(
    parameter logic [3:0]  NODE_ID     = 4'd0,
    parameter int          NODE_NUM    = 12,
    parameter logic [15:0] TIMEOUT_CYC = 16'd4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sync_init,
    input  logic [11:0] sync_target,
    output logic        sync_hit,
    input  logic        ack_valid,
    input  logic [3:0]  ack_src_id,
    output logic        ack_ready,
    output logic        busy,
    output logic        err_timeout
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HIT     = 2'd2
    } state_t;

    localparam logic [4:0] NN = 5'(NODE_NUM);

    state_t      state_q;
    logic [11:0] pend_q;
    logic [11:0] early_q;
    logic        hit_q;
    logic        busy_q;
    logic        err_q;

    logic [11:0] valid_mask;
    logic [11:0] self_mask;
    logic [11:0] ack_bit;
    logic [11:0] ack_acc_bit;
    logic [11:0] tgt_eff;
    logic [11:0] init_pend;
    logic [11:0] coll_pend;
    logic        src_ok;
    logic        acc;

    // Mask of node bits that exist in this configuration.
    always_comb begin
        valid_mask = '0;
        for (int i = 0; i < 12; i++) begin
            valid_mask[i] = (i < NODE_NUM);
        end
    end

    assign self_mask   = 12'd1 << NODE_ID;
    assign src_ok      = ({1'b0, ack_src_id} < NN);
    assign ack_bit     = src_ok ? (12'd1 << ack_src_id) : 12'd0;
    // Ready depends only on state, early mask and source id, never on valid.
    assign ack_ready   = !((state_q == IDLE) && (|(early_q & ack_bit)));
    assign acc         = ack_valid && ack_ready;
    assign ack_acc_bit = acc ? ack_bit : 12'd0;
    assign tgt_eff     = sync_target & ~self_mask & valid_mask;
    assign init_pend   = tgt_eff & ~early_q & ~ack_acc_bit;
    assign coll_pend   = pend_q & ~ack_acc_bit;

    assign sync_hit    = hit_q;
    assign busy        = busy_q;
    assign err_timeout = err_q;

`ifdef DNOC_SYNC_TIMEOUT_EN
    logic [15:0] wd_q;

    // Collection FSM with watchdog; outputs registered alongside state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pend_q  <= '0;
            early_q <= '0;
            hit_q   <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            wd_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (sync_init) begin
                        pend_q  <= init_pend;
                        early_q <= (early_q | ack_acc_bit) & ~tgt_eff;
                        err_q   <= 1'b0;
                        wd_q    <= '0;
                        busy_q  <= 1'b1;
                        if (init_pend == 12'd0) begin
                            state_q <= HIT;
                            hit_q   <= 1'b1;
                        end else begin
                            state_q <= COLLECT;
                        end
                    end else begin
                        early_q <= early_q | ack_acc_bit;
                    end
                end
                COLLECT: begin
                    pend_q  <= coll_pend;
                    early_q <= early_q | (ack_acc_bit & ~pend_q);
                    if (coll_pend == 12'd0) begin
                        state_q <= HIT;
                        hit_q   <= 1'b1;
                    end else if (wd_q == TIMEOUT_CYC - 16'd1) begin
                        state_q <= HIT;
                        hit_q   <= 1'b1;
                        err_q   <= 1'b1;
                        pend_q  <= '0;
                    end else begin
                        wd_q <= wd_q + 16'd1;
                    end
                end
                HIT: begin
                    state_q <= IDLE;
                    hit_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    early_q <= early_q | ack_acc_bit;
                end
                default: begin
                    state_q <= IDLE;
                    hit_q   <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^TIMEOUT_CYC;

    // Collection FSM without watchdog; COLLECT waits indefinitely.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pend_q  <= '0;
            early_q <= '0;
            hit_q   <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (sync_init) begin
                        pend_q  <= init_pend;
                        early_q <= (early_q | ack_acc_bit) & ~tgt_eff;
                        busy_q  <= 1'b1;
                        if (init_pend == 12'd0) begin
                            state_q <= HIT;
                            hit_q   <= 1'b1;
                        end else begin
                            state_q <= COLLECT;
                        end
                    end else begin
                        early_q <= early_q | ack_acc_bit;
                    end
                end
                COLLECT: begin
                    pend_q  <= coll_pend;
                    early_q <= early_q | (ack_acc_bit & ~pend_q);
                    if (coll_pend == 12'd0) begin
                        state_q <= HIT;
                        hit_q   <= 1'b1;
                    end
                end
                HIT: begin
                    state_q <= IDLE;
                    hit_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    early_q <= early_q | ack_acc_bit;
                end
                default: begin
                    state_q <= IDLE;
                    hit_q   <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end
`endif

endmodule
